// File: rtl/screen_pkg.sv
// Shared constants and types for the screen-to-coordinate reverse path.
package screen_pkg;

    // Pixel coordinate width and default raster size.
    localparam int PW         = 16;
    localparam int WIDTH_DEF  = 320;
    localparam int HEIGHT_DEF = 200;

    // Normalized coordinate width and number of divider steps per result.
    localparam int COORD_W    = 8;
    localparam int DIV_STEPS  = 8;
    localparam int STEP_W     = $clog2(DIV_STEPS);

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/from_screen_if.sv
// Request/result bundle for from_screen.
//
// Handshake: a request is taken on a rising ACLK edge where ENB and READY are
// both high; Xpix/Ypix are sampled on that edge. VALID is a single-cycle
// strobe marking Xcoord/Ycoord/OOR as the result of the oldest accepted
// request. There is no result back-pressure, and ENB while READY is low is
// ignored (nothing is queued).
interface from_screen_if;
    import screen_pkg::*;

    logic                       ENB;
    logic                       READY;
    logic [PW-1:0]              Xpix;
    logic [PW-1:0]              Ypix;
    logic signed [COORD_W-1:0]  Xcoord;
    logic signed [COORD_W-1:0]  Ycoord;
    logic                       VALID;
    logic                       OOR;

    // Requester side.
    modport master (
        output ENB, Xpix, Ypix,
        input  READY, Xcoord, Ycoord, VALID, OOR
    );

    // from_screen side.
    modport slave (
        input  ENB, Xpix, Ypix,
        output READY, Xcoord, Ycoord, VALID, OOR
    );
endinterface

// File: rtl/frac_div8.sv
// One restoring-divider lane: q = floor(pix * 256 / DIM), one bit per step,
// MSB first. pix must be below DIM so the remainder always fits PW bits.
// q and done are look-ahead: they show the value after the step in progress,
// so the controller can register the final quotient on the last step edge.
module frac_div8
    import screen_pkg::*;
#(
    parameter int DIM = WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [PW-1:0] pix,
    output logic [7:0]    q,
    output logic          done
);

    localparam logic [PW:0] DIV = (PW+1)'(DIM);

    // Shift register holds the quotient bits with a marker one above them;
    // the marker leaves bit 7 on the eighth step.
    logic [PW-1:0] rem_q, rem_d;
    logic [7:0]    sr_q,  sr_d;
    logic [PW:0]   t;
    logic [PW:0]   diff;
    logic          ge;

    // Next remainder/quotient: load the numerator or perform one restoring step.
    always_comb begin
        t     = {rem_q, 1'b0};
        ge    = (t >= DIV);
        diff  = t - DIV;
        rem_d = rem_q;
        sr_d  = sr_q;
        if (load) begin
            rem_d = pix;
            sr_d  = 8'd1;
        end else if (step) begin
            rem_d = ge ? diff[PW-1:0] : t[PW-1:0];
            sr_d  = {sr_q[6:0], ge};
        end
    end

    assign q    = sr_d;
    assign done = step && !load && sr_q[7];

    // Remainder and quotient registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            sr_q  <= '0;
        end else begin
            rem_q <= rem_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/from_screen.sv
// from_screen: pixel position -> signed 8-bit normalized coordinate pair.
// coord = floor(pix * 256 / DIM) - 128 per axis, two divider lanes in parallel.
// An out-of-range axis clamps to +127 (still taking the full latency) and
// raises OOR. Build option FROM_SCREEN_YFLIP_EN: row 0 is the top of the
// screen, Y is bit-inverted and an out-of-range Y clamps to -128.
module from_screen
    import screen_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    from_screen_if.slave      bus,
    output logic [1:0]        dbg_state,
    output logic [STEP_W-1:0] dbg_step
);

    // Reject rasters the divider cannot handle.
    generate
        if (WIDTH < 2 || HEIGHT < 2 || WIDTH >= (1 << PW) || HEIGHT >= (1 << PW)) begin : g_bad_dim
            $error("from_screen: WIDTH/HEIGHT must be in 2..2**PW-1");
        end
    endgenerate

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] DONE = ST_DONE;

    localparam logic [PW-1:0] W_PIX   = PW'(WIDTH);
    localparam logic [PW-1:0] H_PIX   = PW'(HEIGHT);
    localparam logic [7:0]    X_CLAMP = 8'h7f;
`ifdef FROM_SCREEN_YFLIP_EN
    localparam logic [7:0]    Y_CLAMP = 8'h80;
`else
    localparam logic [7:0]    Y_CLAMP = 8'h7f;
`endif

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic              oor_x_q, oor_x_d;
    logic              oor_y_q, oor_y_d;
    logic              valid_q, valid_d;
    logic              oor_q,   oor_d;
    logic [7:0]        xcoord_q, xcoord_d;
    logic [7:0]        ycoord_q, ycoord_d;

    logic              accept;
    logic              run;
    logic              x_oor_in, y_oor_in;
    logic [PW-1:0]     x_num, y_num;
    logic [7:0]        q_x, q_y;
    logic              done_x, done_y;
    logic [7:0]        y_map;

    assign accept   = bus.ENB && (state_q == IDLE);
    assign run      = (state_q == RUN);
    assign x_oor_in = (bus.Xpix >= W_PIX);
    assign y_oor_in = (bus.Ypix >= H_PIX);
    // An out-of-range axis divides zero so its remainder stays bounded.
    assign x_num    = x_oor_in ? '0 : bus.Xpix;
    assign y_num    = y_oor_in ? '0 : bus.Ypix;

    frac_div8 #(.DIM(WIDTH)) u_div_x (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .load  (accept),
        .step  (run),
        .pix   (x_num),
        .q     (q_x),
        .done  (done_x)
    );

    frac_div8 #(.DIM(HEIGHT)) u_div_y (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .load  (accept),
        .step  (run),
        .pix   (y_num),
        .q     (q_y),
        .done  (done_y)
    );

    // Y mapping: subtract 128 by flipping the MSB, optionally invert for top-origin rows.
`ifdef FROM_SCREEN_YFLIP_EN
    assign y_map = ~(q_y ^ 8'h80);
`else
    assign y_map = q_y ^ 8'h80;
`endif

    // Controller: IDLE -> RUN (8 steps) -> DONE -> IDLE; result registered on the last step.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        oor_x_d  = oor_x_q;
        oor_y_d  = oor_y_q;
        valid_d  = 1'b0;
        oor_d    = oor_q;
        xcoord_d = xcoord_q;
        ycoord_d = ycoord_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    step_d  = '0;
                    oor_x_d = x_oor_in;
                    oor_y_d = y_oor_in;
                end
            end
            RUN: begin
                step_d = step_q + 1'b1;
                if (done_x && done_y) begin
                    state_d  = DONE;
                    valid_d  = 1'b1;
                    oor_d    = oor_x_q || oor_y_q;
                    xcoord_d = oor_x_q ? X_CLAMP : (q_x ^ 8'h80);
                    ycoord_d = oor_y_q ? Y_CLAMP : y_map;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= IDLE;
            step_q   <= '0;
            oor_x_q  <= 1'b0;
            oor_y_q  <= 1'b0;
            valid_q  <= 1'b0;
            oor_q    <= 1'b0;
            xcoord_q <= '0;
            ycoord_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            oor_x_q  <= oor_x_d;
            oor_y_q  <= oor_y_d;
            valid_q  <= valid_d;
            oor_q    <= oor_d;
            xcoord_q <= xcoord_d;
            ycoord_q <= ycoord_d;
        end
    end

    assign bus.READY  = (state_q == IDLE);
    assign bus.VALID  = valid_q;
    assign bus.OOR    = oor_q;
    assign bus.Xcoord = xcoord_q;
    assign bus.Ycoord = ycoord_q;
    assign dbg_state  = state_q;
    assign dbg_step   = step_q;

endmodule

// File: tb/tb_from_screen.sv
// Testbench for from_screen: directed cases, reset mid-run, then random
// pixel positions checked against an arithmetic reference model.
module tb_from_screen;
    import screen_pkg::*;

    localparam int WIDTH  = WIDTH_DEF;
    localparam int HEIGHT = HEIGHT_DEF;
`ifdef FROM_SCREEN_YFLIP_EN
    localparam bit YFLIP = 1'b1;
`else
    localparam bit YFLIP = 1'b0;
`endif

    logic              ACLK;
    logic              ARESETN;
    logic [1:0]        dbg_state;
    logic [STEP_W-1:0] dbg_step;

    from_screen_if bus ();

    from_screen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_step  (dbg_step)
    );

    // Clock and reset.
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard entries: {oor, xcoord, ycoord}.
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: floor(pix*256/dim) - 128, clamped for out-of-range pixels.
    function automatic logic [7:0] model_coord(input int pix, input int dim, input bit is_y);
        int q;
        logic [7:0] c;
        if (pix >= dim) begin
            c = (is_y && YFLIP) ? 8'h80 : 8'h7f;
        end else begin
            q = (pix * 256) / dim;
            c = 8'(q - 128);
            if (is_y && YFLIP) c = ~c;
        end
        return c;
    endfunction

    // Issue one request and follow it cycle by cycle through E9.
    task automatic run_req(input int px, input int py, input bit hold_enb);
        logic [16:0] e;
        e = {((px >= WIDTH) || (py >= HEIGHT)) ? 1'b1 : 1'b0,
             model_coord(px, WIDTH, 1'b0),
             model_coord(py, HEIGHT, 1'b1)};
        exp_q.push_back(e);
        check("ready_before_req", {31'd0, bus.READY}, 32'd1);
        bus.ENB  = 1'b1;
        bus.Xpix = PW'(px);
        bus.Ypix = PW'(py);
        @(posedge ACLK);
        if (!hold_enb) #1 bus.ENB = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            @(negedge ACLK);
            check($sformatf("ready_e%0d", k), {31'd0, bus.READY}, (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("valid_e%0d", k), {31'd0, bus.VALID}, (k == 8) ? 32'd1 : 32'd0);
            if (k == 8) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("oor(%0d,%0d)", px, py), {31'd0, bus.OOR}, {31'd0, e[16]});
                    check($sformatf("xcoord(%0d,%0d)", px, py), {24'd0, bus.Xcoord}, {24'd0, e[15:8]});
                    check($sformatf("ycoord(%0d,%0d)", px, py), {24'd0, bus.Ycoord}, {24'd0, e[7:0]});
                end
            end
            if (k == 9) begin
                check("xcoord_hold", {24'd0, bus.Xcoord}, {24'd0, e[15:8]});
                check("ycoord_hold", {24'd0, bus.Ycoord}, {24'd0, e[7:0]});
                bus.ENB = 1'b0;
            end else begin
                @(posedge ACLK);
            end
        end
    endtask

    // Reset asserted after step 4: outputs return to reset values, no VALID follows.
    task automatic reset_mid_run(input int px, input int py);
        check("ready_before_rst_req", {31'd0, bus.READY}, 32'd1);
        bus.ENB  = 1'b1;
        bus.Xpix = PW'(px);
        bus.Ypix = PW'(py);
        @(posedge ACLK);
        #1 bus.ENB = 1'b0;
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        check("rst_ready",  {31'd0, bus.READY}, 32'd1);
        check("rst_valid",  {31'd0, bus.VALID}, 32'd0);
        check("rst_oor",    {31'd0, bus.OOR},   32'd0);
        check("rst_xcoord", {24'd0, bus.Xcoord}, 32'd0);
        check("rst_ycoord", {24'd0, bus.Ycoord}, 32'd0);
        check("rst_state",  {30'd0, dbg_state}, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ACLK);
            check("no_valid_after_rst", {31'd0, bus.VALID}, 32'd0);
        end
    endtask

    // Stimulus: reset checks, directed table, reset mid-run, random requests.
    initial begin
        int dir_x[7] = '{0, 160, 319, 200, 320, 50, 319};
        int dir_y[7] = '{0, 100, 199, 100, 50, 250, 200};
        ARESETN  = 1'b0;
        bus.ENB  = 1'b0;
        bus.Xpix = '0;
        bus.Ypix = '0;
        repeat (3) @(negedge ACLK);
        check("reset_ready",  {31'd0, bus.READY}, 32'd1);
        check("reset_valid",  {31'd0, bus.VALID}, 32'd0);
        check("reset_oor",    {31'd0, bus.OOR},   32'd0);
        check("reset_xcoord", {24'd0, bus.Xcoord}, 32'd0);
        check("reset_ycoord", {24'd0, bus.Ycoord}, 32'd0);
        check("reset_state",  {30'd0, dbg_state}, 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Model spot checks against hand-computed values.
        check("model_x0",   {24'd0, model_coord(0, WIDTH, 1'b0)},   32'h80);
        check("model_x319", {24'd0, model_coord(319, WIDTH, 1'b0)}, 32'h7f);
        check("model_x200", {24'd0, model_coord(200, WIDTH, 1'b0)}, 32'h20);

        for (int i = 0; i < 7; i++) begin
            run_req(dir_x[i], dir_y[i], (i == 4) ? 1'b1 : 1'b0);
        end

        reset_mid_run(123, 77);
        run_req(0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_req(int'($urandom_range(0, WIDTH + 20)),
                    int'($urandom_range(0, HEIGHT + 10)),
                    1'(($urandom_range(0, 3) == 0) ? 1 : 0));
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
